rs_muldiv_array: RTL and testbench

Multi-entry reservation station for the shared multiply/divide unit, replacing the single-entry multiply station. It holds up to DEPTH issued mul/div operations and renames each one to its own tag. It snoops the CDB for outstanding source operands, and dispatches one ready entry at a time into an internal latency counter that models the iterative mul/div datapath. It sits between the issue stage/rename table and the mul/div functional unit, which receives operands on the exe_* bus.

---
 rtl/rs_muldiv_array.sv | 227 ++++++++++++++++++++++
 tb/tb_rs_muldiv_array.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_muldiv_array.sv
// Multi-entry reservation station for the shared mul/div unit: it renames issues to per-entry tags, snoops the CDB and feeds an iterative latency model.
// Optional macro RS_AGE_PRIORITY_EN selects oldest-first dispatch through an age matrix; when undefined, dispatch is lowest-index-first.
module rs_muldiv_array #(
    parameter int DEPTH    = 4,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int TAG_BASE = 4,
    parameter int MUL_LAT  = 10,
    parameter int DIV_LAT  = 40
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [2:0]                 issue_op,
    input  logic [DATA_W-1:0]          issue_vj,
    input  logic [DATA_W-1:0]          issue_vk,
    input  logic [TAG_W-1:0]           issue_qj,
    input  logic [TAG_W-1:0]           issue_qk,
    output logic [TAG_W-1:0]           issue_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    output logic                       exe_valid,
    output logic [2:0]                 exe_op,
    output logic [DATA_W-1:0]          exe_vj,
    output logic [DATA_W-1:0]          exe_vk,
    output logic [TAG_W-1:0]           exe_tag,
    output logic                       done_valid,
    output logic [TAG_W-1:0]           done_tag,
    output logic [$clog2(DEPTH+1)-1:0] busy_count
);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int TMR_W   = ($clog2(MAX_LAT) > 6) ? $clog2(MAX_LAT) : 6;

    logic [DEPTH-1:0]  busy_q, disp_q;
    logic [2:0]        op_q [DEPTH];
    logic [DATA_W-1:0] vj_q [DEPTH];
    logic [DATA_W-1:0] vk_q [DEPTH];
    logic [TAG_W-1:0]  qj_q [DEPTH];
    logic [TAG_W-1:0]  qk_q [DEPTH];

    logic              exe_valid_q, exe_valid_d;
    logic [2:0]        exe_op_q, exe_op_d;
    logic [DATA_W-1:0] exe_vj_q, exe_vj_d, exe_vk_q, exe_vk_d;
    logic [TAG_W-1:0]  exe_tag_q, exe_tag_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [DEPTH-1:0]  ready, sel;
    logic              free_any, disp_any, done, do_issue, do_disp;
    logic [IDX_W-1:0]  free_idx, disp_idx;
    logic              cap_j, cap_k;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ready
        assign ready[gi] = busy_q[gi] && !disp_q[gi] && (qj_q[gi] == '0) && (qk_q[gi] == '0);
    end

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

`ifdef RS_AGE_PRIORITY_EN
    // age_q[j][i] = 1 means entry j was issued before entry i
    logic [DEPTH-1:0] age_q [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            sel[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && age_q[j][i]) sel[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else if (!flush) begin
            if (done) begin
                for (int j = 0; j < DEPTH; j++) begin
                    age_q[idx_q][j] <= 1'b0;
                    age_q[j][idx_q] <= 1'b0;
                end
            end
            if (do_issue) begin
                for (int j = 0; j < DEPTH; j++) begin
                    age_q[free_idx][j] <= 1'b0;
                    if (j != int'(free_idx)) age_q[j][free_idx] <= 1'b1;
                end
            end
        end
    end
`else
    assign sel = ready;
`endif

    always_comb begin
        disp_any = 1'b0;
        disp_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (sel[i]) begin
                disp_any = 1'b1;
                disp_idx = IDX_W'(i);
            end
        end
    end

    assign done     = exe_valid_q && (timer_q == '0);
    assign do_issue = issue_valid && free_any && !flush;
    assign do_disp  = (!exe_valid_q || done) && disp_any && !flush;
    assign cap_j    = cdb_valid && (issue_qj != '0) && (issue_qj == cdb_tag);
    assign cap_k    = cdb_valid && (issue_qk != '0) && (issue_qk == cdb_tag);

    always_comb begin
        exe_valid_d = exe_valid_q;
        exe_op_d    = exe_op_q;
        exe_vj_d    = exe_vj_q;
        exe_vk_d    = exe_vk_q;
        exe_tag_d   = exe_tag_q;
        timer_d     = timer_q;
        idx_d       = idx_q;
        if (exe_valid_q && timer_q != '0) timer_d = timer_q - 1'b1;
        if (done) exe_valid_d = 1'b0;
        if (do_disp) begin
            exe_valid_d = 1'b1;
            exe_op_d    = op_q[disp_idx];
            exe_vj_d    = vj_q[disp_idx];
            exe_vk_d    = vk_q[disp_idx];
            exe_tag_d   = TAG_W'(TAG_BASE) + TAG_W'(disp_idx);
            idx_d       = disp_idx;
            timer_d     = (op_q[disp_idx] == 3'd2) ? TMR_W'(MUL_LAT - 1) : TMR_W'(DIV_LAT - 1);
        end
        if (flush) begin
            exe_valid_d = 1'b0;
            timer_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_valid_q <= 1'b0;
            exe_op_q    <= '0;
            exe_vj_q    <= '0;
            exe_vk_q    <= '0;
            exe_tag_q   <= '0;
            timer_q     <= '0;
            idx_q       <= '0;
        end else begin
            exe_valid_q <= exe_valid_d;
            exe_op_q    <= exe_op_d;
            exe_vj_q    <= exe_vj_d;
            exe_vk_q    <= exe_vk_d;
            exe_tag_q   <= exe_tag_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
        end
    end

    // Issue, snoop, dispatch and free always touch distinct entries in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            disp_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i] <= '0;
                vj_q[i] <= '0;
                vk_q[i] <= '0;
                qj_q[i] <= '0;
                qk_q[i] <= '0;
            end
        end else if (flush) begin
            busy_q <= '0;
            disp_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && cdb_valid && qj_q[i] != '0 && qj_q[i] == cdb_tag) begin
                    vj_q[i] <= cdb_data;
                    qj_q[i] <= '0;
                end
                if (busy_q[i] && cdb_valid && qk_q[i] != '0 && qk_q[i] == cdb_tag) begin
                    vk_q[i] <= cdb_data;
                    qk_q[i] <= '0;
                end
            end
            if (do_disp) disp_q[disp_idx] <= 1'b1;
            if (done) begin
                busy_q[idx_q] <= 1'b0;
                disp_q[idx_q] <= 1'b0;
            end
            if (do_issue) begin
                busy_q[free_idx] <= 1'b1;
                disp_q[free_idx] <= 1'b0;
                op_q[free_idx]   <= issue_op;
                vj_q[free_idx]   <= cap_j ? cdb_data : issue_vj;
                vk_q[free_idx]   <= cap_k ? cdb_data : issue_vk;
                qj_q[free_idx]   <= cap_j ? '0 : issue_qj;
                qk_q[free_idx]   <= cap_k ? '0 : issue_qk;
            end
        end
    end

    always_comb begin
        busy_count = '0;
        for (int i = 0; i < DEPTH; i++) busy_count = busy_count + CNT_W'(busy_q[i]);
    end

    assign issue_ready = free_any;
    assign issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
    assign exe_valid   = exe_valid_q;
    assign exe_op      = exe_op_q;
    assign exe_vj      = exe_vj_q;
    assign exe_vk      = exe_vk_q;
    assign exe_tag     = exe_tag_q;
    assign done_valid  = done && !flush;
    assign done_tag    = done_valid ? exe_tag_q : '0;
endmodule

// File: tb/tb_rs_muldiv_array.sv
// Directed bench for rs_muldiv_array: stimulus pushes expected completions, a negedge monitor pops and checks them.
module tb_rs_muldiv_array;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [2:0]  issue_op = '0;
    logic [31:0] issue_vj = '0, issue_vk = '0;
    logic [3:0]  issue_qj = '0, issue_qk = '0;
    logic [3:0]  issue_tag;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        exe_valid;
    logic [2:0]  exe_op;
    logic [31:0] exe_vj, exe_vk;
    logic [3:0]  exe_tag;
    logic        done_valid;
    logic [3:0]  done_tag;
    logic [2:0]  busy_count;

    rs_muldiv_array dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
        .issue_tag(issue_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .exe_valid(exe_valid), .exe_op(exe_op), .exe_vj(exe_vj), .exe_vk(exe_vk), .exe_tag(exe_tag),
        .done_valid(done_valid), .done_tag(done_tag), .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [2:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   run_len = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] tag, input logic [2:0] op, input logic [31:0] vj, input logic [31:0] vk);
        exp_t e;
        e.tag = tag;
        e.op  = op;
        e.vj  = vj;
        e.vk  = vk;
        e.lat = (op == 3'd2) ? 10 : 40;
        exp_q.push_back(e);
    endtask

    task automatic do_issue(input logic [2:0] op, input logic [31:0] vj, input logic [31:0] vk, input logic [3:0] qj, input logic [3:0] qk);
        issue_valid = 1'b1;
        issue_op = op;
        issue_vj = vj;
        issue_vk = vk;
        issue_qj = qj;
        issue_qk = qk;
        tick();
        issue_valid = 1'b0;
        $display("issue op=%0d vj=%0h vk=%0h qj=%0d qk=%0d", op, vj, vk, qj, qk);
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag = tag;
        cdb_data = data;
        tick();
        cdb_valid = 1'b0;
        $display("cdb tag=%0d data=%0h", tag, data);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((busy_count != 3'd0 || exp_q.size() != 0) && n < maxc) begin
            tick();
            n++;
        end
        chk("idle_busy_count", 64'(busy_count), 64'd0);
        chk("idle_pending", 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exe_valid) run_len++;
        else run_len = 0;
        if (done_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(done_tag), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                $display("done tag=%0d op=%0d vj=%0h vk=%0h len=%0d", done_tag, exe_op, exe_vj, exe_vk, run_len);
                chk("done_tag", 64'(done_tag), 64'(e.tag));
                chk("exe_op", 64'(exe_op), 64'(e.op));
                chk("exe_vj", 64'(exe_vj), 64'(e.vj));
                chk("exe_vk", 64'(exe_vk), 64'(e.vk));
                chk("exe_len", 64'(run_len), 64'(e.lat));
            end
            run_len = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #2;
        chk("rst_exe_valid", 64'(exe_valid), 64'd0);
        chk("rst_done_valid", 64'(done_valid), 64'd0);
        chk("rst_busy_count", 64'(busy_count), 64'd0);
        chk("rst_issue_tag", 64'(issue_tag), 64'd4);
        #20 rst_n = 1'b1;
        tick();
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);

        // Single MUL with valid operands
        chk("t1_issue_tag", 64'(issue_tag), 64'd4);
        do_issue(3'd2, 32'd3, 32'd5, 4'd0, 4'd0);
        push(4'd4, 3'd2, 32'd3, 32'd5);
        chk("t1_busy_count", 64'(busy_count), 64'd1);
        chk("t1_not_yet_exe", 64'(exe_valid), 64'd0);
        tick();
        chk("t1_exe_valid", 64'(exe_valid), 64'd1);
        chk("t1_exe_tag", 64'(exe_tag), 64'd4);
        wait_idle(100);

        // DIV waiting on CDB tag 9
        do_issue(3'd3, 32'hDEAD, 32'd7, 4'd9, 4'd0);
        push(4'd4, 3'd3, 32'h20, 32'd7);
        tick();
        tick();
        chk("t2_waiting", 64'(exe_valid), 64'd0);
        cdb(4'd9, 32'h20);
        chk("t2_cdb_edge", 64'(exe_valid), 64'd0);
        tick();
        chk("t2_dispatched", 64'(exe_valid), 64'd1);
        chk("t2_exe_vj", 64'(exe_vj), 64'h20);
        wait_idle(200);

        // Fill all entries, overflow attempt, then release together
        for (int i = 0; i < 4; i++) begin
            chk("t3_issue_tag", 64'(issue_tag), 64'(4 + i));
            do_issue(3'd2, 32'd0, 32'(i + 1), 4'd9, 4'd0);
            push(4'(4 + i), 3'd2, 32'h11, 32'(i + 1));
        end
        chk("t3_full_ready", 64'(issue_ready), 64'd0);
        chk("t3_full_count", 64'(busy_count), 64'd4);
        do_issue(3'd2, 32'd0, 32'h99, 4'd0, 4'd0);
        chk("t3_ignored_count", 64'(busy_count), 64'd4);
        chk("t3_ignored_exe", 64'(exe_valid), 64'd0);
        cdb(4'd9, 32'h11);
        wait_idle(200);

        // Ready entry overtakes a waiting one
        do_issue(3'd2, 32'd0, 32'd1, 4'd9, 4'd0);
        do_issue(3'd2, 32'd2, 32'd2, 4'd0, 4'd0);
        push(4'd5, 3'd2, 32'd2, 32'd2);
        push(4'd4, 3'd2, 32'h30, 32'd1);
        cdb(4'd9, 32'h30);
        wait_idle(200);

        // Entry 0 re-issued last, then everything ready at once
        do_issue(3'd2, 32'd1, 32'd1, 4'd0, 4'd0);
        push(4'd4, 3'd2, 32'd1, 32'd1);
        for (int i = 1; i < 4; i++) begin
            chk("t4_issue_tag", 64'(issue_tag), 64'(4 + i));
            do_issue(3'd2, 32'd0, 32'(16 + i), 4'd9, 4'd0);
        end
        n = 0;
        while (busy_count != 3'd3 && n < 50) begin
            tick();
            n++;
        end
        chk("t4_freed", 64'(busy_count), 64'd3);
        chk("t4_refill_tag", 64'(issue_tag), 64'd4);
        do_issue(3'd2, 32'd0, 32'd16, 4'd9, 4'd0);
`ifdef RS_AGE_PRIORITY_EN
        push(4'd5, 3'd2, 32'h40, 32'd17);
        push(4'd6, 3'd2, 32'h40, 32'd18);
        push(4'd7, 3'd2, 32'h40, 32'd19);
        push(4'd4, 3'd2, 32'h40, 32'd16);
`else
        push(4'd4, 3'd2, 32'h40, 32'd16);
        push(4'd5, 3'd2, 32'h40, 32'd17);
        push(4'd6, 3'd2, 32'h40, 32'd18);
        push(4'd7, 3'd2, 32'h40, 32'd19);
`endif
        cdb(4'd9, 32'h40);
        wait_idle(300);

        // Capture on the issue edge
        cdb_valid = 1'b1;
        cdb_tag = 4'd6;
        cdb_data = 32'h55;
        do_issue(3'd2, 32'd0, 32'd1, 4'd6, 4'd0);
        cdb_valid = 1'b0;
        push(4'd4, 3'd2, 32'h55, 32'd1);
        chk("t5_not_yet_exe", 64'(exe_valid), 64'd0);
        tick();
        chk("t5_exe_valid", 64'(exe_valid), 64'd1);
        chk("t5_exe_vj", 64'(exe_vj), 64'h55);
        wait_idle(100);

        // Flush landing on a completion cycle with 3 entries busy
        do_issue(3'd2, 32'd1, 32'd1, 4'd0, 4'd0);
        push(4'd4, 3'd2, 32'd1, 32'd1);
        do_issue(3'd2, 32'd0, 32'd0, 4'd9, 4'd0);
        do_issue(3'd2, 32'd0, 32'd0, 4'd9, 4'd0);
        chk("t6_busy3", 64'(busy_count), 64'd3);
        n = 0;
        while (!done_valid && n < 50) begin
            tick();
            n++;
        end
        chk("t6_reach_done", 64'(done_valid), 64'd1);
        flush = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_flush_no_done", 64'(done_valid), 64'd0);
        tick();
        flush = 1'b0;
        $display("flush applied");
        chk("t6_exe_valid", 64'(exe_valid), 64'd0);
        chk("t6_busy_count", 64'(busy_count), 64'd0);
        chk("t6_issue_ready", 64'(issue_ready), 64'd1);
        chk("t6_issue_tag", 64'(issue_tag), 64'd4);
        repeat (15) tick();

        // Asynchronous reset mid-execution
        do_issue(3'd3, 32'd7, 32'd8, 4'd0, 4'd0);
        push(4'd4, 3'd3, 32'd7, 32'd8);
        do_issue(3'd2, 32'd0, 32'd0, 4'd9, 4'd0);
        do_issue(3'd2, 32'd0, 32'd0, 4'd9, 4'd0);
        repeat (5) tick();
        chk("t7_pre_exe_valid", 64'(exe_valid), 64'd1);
        chk("t7_pre_exe_vj", 64'(exe_vj), 64'd7);
        chk("t7_pre_busy", 64'(busy_count), 64'd3);
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1;
        $display("async reset asserted");
        chk("t7_exe_valid", 64'(exe_valid), 64'd0);
        chk("t7_exe_op", 64'(exe_op), 64'd0);
        chk("t7_exe_vj", 64'(exe_vj), 64'd0);
        chk("t7_exe_vk", 64'(exe_vk), 64'd0);
        chk("t7_exe_tag", 64'(exe_tag), 64'd0);
        chk("t7_done_valid", 64'(done_valid), 64'd0);
        chk("t7_done_tag", 64'(done_tag), 64'd0);
        chk("t7_busy_count", 64'(busy_count), 64'd0);
        #13 rst_n = 1'b1;
        tick();
        chk("t7_issue_ready", 64'(issue_ready), 64'd1);
        chk("t7_issue_tag", 64'(issue_tag), 64'd4);
        repeat (5) tick();
        chk("final_pending", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
